// File: rtl/gin_pe_input_fifo.sv
// gin_pe_input_fifo
// Receive-side buffer between a GIN multicast controller and the PE
// scratchpad loader. Words forwarded by the controller are captured into a
// small register array. They are presented to the PE through a
// first-word-fall-through valid/ready port.
//
// Handshake semantics (both ports):
//   A transfer happens at a rising edge of link_clk exactly when the
//   sender's valid/enable and the receiver's ready are both high in the
//   cycle before that edge. A sender holds its word stable until the
//   transfer. Ready never depends combinationally on the partner's valid.
//   Upstream:   enable_in (valid) / ready_out (ready), word on data_in.
//   Downstream: valid_out (valid) / ready_in (ready), word on data_out.

module gin_pe_input_fifo #(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 4,
    parameter int CNT_WIDTH  = $clog2(DEPTH) + 1
) (
    input  logic                  link_clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  enable_in,
    output logic                  ready_out,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    input  logic                  ready_in,
    output logic [CNT_WIDTH-1:0]  count,
    output logic                  overflow_err
);

    localparam int PTR_WIDTH = $clog2(DEPTH);
    localparam logic [CNT_WIDTH-1:0] FULL_COUNT = CNT_WIDTH'(DEPTH);
    localparam logic [CNT_WIDTH-1:0] ONE_COUNT  = CNT_WIDTH'(1);
    localparam logic [PTR_WIDTH-1:0] ONE_PTR    = PTR_WIDTH'(1);

    // Storage and bookkeeping state. The array itself is never reset.
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_WIDTH-1:0]  wr_ptr;
    logic [PTR_WIDTH-1:0]  rd_ptr;
    logic [CNT_WIDTH-1:0]  count_q;
    logic                  overflow_q;

    // Qualified transfer strobes for this cycle.
    logic wr_en;
    logic rd_en;
    logic overflow_hit;

    // Flags derived purely from the registered occupancy. A read in a full
    // cycle does not open a slot until the next cycle, so there is no
    // write-through path from ready_in to ready_out.
    always_comb begin
        ready_out = (count_q != FULL_COUNT);
        valid_out = (count_q != '0);
    end

    // Transfer qualification. An enable while full is dropped and only
    // raises the sticky error; an empty queue ignores ready_in.
    always_comb begin
        wr_en        = enable_in & ready_out;
        rd_en        = valid_out & ready_in;
        overflow_hit = enable_in & ~ready_out;
    end

    // Head word presented to the PE; forced to zero while the queue is
    // empty so stale array contents never appear on the bus.
    always_comb begin
        data_out = '0;
        if (valid_out) begin
            data_out = mem[rd_ptr];
        end
    end

    always_comb begin
        count        = count_q;
        overflow_err = overflow_q;
    end

    // Array write: capture the upstream word at the write pointer.
    always_ff @(posedge link_clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= data_in;
        end
    end

    // Write pointer: advances on every accepted word, wraps modulo DEPTH.
    always_ff @(posedge link_clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
        end else if (wr_en) begin
            wr_ptr <= wr_ptr + ONE_PTR;
        end
    end

    // Read pointer: advances on every word taken by the PE, wraps modulo DEPTH.
    always_ff @(posedge link_clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
        end else if (rd_en) begin
            rd_ptr <= rd_ptr + ONE_PTR;
        end
    end

    // Occupancy: +1 on write only, -1 on read only, unchanged otherwise.
    always_ff @(posedge link_clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            case ({wr_en, rd_en})
                2'b10:   count_q <= count_q + ONE_COUNT;
                2'b01:   count_q <= count_q - ONE_COUNT;
                default: count_q <= count_q;
            endcase
        end
    end

    // Sticky overflow flag: set by any enable while full, cleared only by reset.
    always_ff @(posedge link_clk or negedge reset) begin
        if (!reset) begin
            overflow_q <= 1'b0;
        end else if (overflow_hit) begin
            overflow_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_gin_pe_input_fifo.sv
// Bench for gin_pe_input_fifo: table of directed vectors, hand-written
// reset sequences, and a queue-model scoreboard over pseudo-random traffic.

module tb_gin_pe_input_fifo;

    localparam int DW = 64;
    localparam int DEPTH = 4;
    localparam int CW = 3;

    logic          link_clk;
    logic          reset;
    logic [DW-1:0] data_in;
    logic          enable_in;
    logic          ready_out;
    logic [DW-1:0] data_out;
    logic          valid_out;
    logic          ready_in;
    logic [CW-1:0] count;
    logic          overflow_err;

    int n_checks = 0;
    int n_fail   = 0;

    gin_pe_input_fifo #(
        .DATA_WIDTH(DW),
        .DEPTH(DEPTH),
        .CNT_WIDTH(CW)
    ) dut (
        .link_clk(link_clk),
        .reset(reset),
        .data_in(data_in),
        .enable_in(enable_in),
        .ready_out(ready_out),
        .data_out(data_out),
        .valid_out(valid_out),
        .ready_in(ready_in),
        .count(count),
        .overflow_err(overflow_err)
    );

    // Clock and reset start state.
    initial begin
        link_clk = 1'b0;
        forever #5 link_clk = ~link_clk;
    end

    typedef struct {
        logic          en;
        logic [DW-1:0] din;
        logic          ri;
        logic          ev;
        logic [DW-1:0] ed;
        logic [CW-1:0] ec;
        logic          er;
        logic          eo;
    } vec_t;

    vec_t vecs[$];
    logic [DW-1:0] exp_q[$];

    task automatic add_vec(input logic en, input logic [DW-1:0] din, input logic ri,
                           input logic ev, input logic [DW-1:0] ed, input logic [CW-1:0] ec,
                           input logic er, input logic eo);
        vec_t v;
        v.en = en; v.din = din; v.ri = ri;
        v.ev = ev; v.ed = ed; v.ec = ec; v.er = er; v.eo = eo;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag, input logic ev, input logic [DW-1:0] ed,
                             input logic [CW-1:0] ec, input logic er, input logic eo);
        check({tag, ".valid_out"}, DW'(valid_out), DW'(ev));
        check({tag, ".data_out"}, data_out, ed);
        check({tag, ".count"}, DW'(count), DW'(ec));
        check({tag, ".ready_out"}, DW'(ready_out), DW'(er));
        check({tag, ".overflow_err"}, DW'(overflow_err), DW'(eo));
    endtask

    // Advance one clock edge; outputs are then sampled 1 time unit later.
    task automatic step();
        @(posedge link_clk);
        #1;
    endtask

    task automatic drive(input logic en, input logic [DW-1:0] din, input logic ri);
        enable_in = en;
        data_in   = din;
        ready_in  = ri;
    endtask

    initial begin
        reset = 1'b0;
        drive(1'b0, '0, 1'b0);

        // Expected state after each edge: valid, data, count, ready, overflow.
        // Fill with ready_in low.
        add_vec(1, 64'h11, 0,  1, 64'h11, 1, 1, 0);
        add_vec(1, 64'h22, 0,  1, 64'h11, 2, 1, 0);
        add_vec(1, 64'h33, 0,  1, 64'h11, 3, 1, 0);
        add_vec(1, 64'h44, 0,  1, 64'h11, 4, 0, 0);
        // Drain.
        add_vec(0, 64'h0,  1,  1, 64'h22, 3, 1, 0);
        add_vec(0, 64'h0,  1,  1, 64'h33, 2, 1, 0);
        add_vec(0, 64'h0,  1,  1, 64'h44, 1, 1, 0);
        add_vec(0, 64'h0,  1,  0, 64'h0,  0, 1, 0);
        // Read on empty is ignored.
        add_vec(0, 64'h0,  1,  0, 64'h0,  0, 1, 0);
        // Hold two entries, then six simultaneous read/write cycles (wrap).
        add_vec(1, 64'hB0, 0,  1, 64'hB0, 1, 1, 0);
        add_vec(1, 64'hB1, 0,  1, 64'hB0, 2, 1, 0);
        add_vec(1, 64'hA0, 1,  1, 64'hB1, 2, 1, 0);
        add_vec(1, 64'hA1, 1,  1, 64'hA0, 2, 1, 0);
        add_vec(1, 64'hA2, 1,  1, 64'hA1, 2, 1, 0);
        add_vec(1, 64'hA3, 1,  1, 64'hA2, 2, 1, 0);
        add_vec(1, 64'hA4, 1,  1, 64'hA3, 2, 1, 0);
        add_vec(1, 64'hA5, 1,  1, 64'hA4, 2, 1, 0);
        // Fill to full.
        add_vec(1, 64'hC0, 0,  1, 64'hA4, 3, 1, 0);
        add_vec(1, 64'hC1, 0,  1, 64'hA4, 4, 0, 0);
        // Full with read and write: head popped, 0xEE dropped, error set.
        add_vec(1, 64'hEE, 1,  1, 64'hA5, 3, 1, 1);
        // Back-pressure: head and count hold for 5 cycles.
        for (int i = 0; i < 5; i++) add_vec(0, 64'h0, 0, 1, 64'hA5, 3, 1, 1);
        // Pop one, then push one to leave 3 entries held.
        add_vec(0, 64'h0,  1,  1, 64'hC0, 2, 1, 1);
        add_vec(1, 64'hD0, 0,  1, 64'hC0, 3, 1, 1);

        // Reset held for 3 cycles, then idle.
        repeat (3) step();
        check_all("in_reset", 0, 0, 0, 1, 0);
        reset = 1'b1;
        step();
        check_all("post_reset_idle", 0, 0, 0, 1, 0);

        // Table-driven section.
        foreach (vecs[i]) begin
            drive(vecs[i].en, vecs[i].din, vecs[i].ri);
            step();
            check_all($sformatf("vec%0d", i), vecs[i].ev, vecs[i].ed, vecs[i].ec,
                      vecs[i].er, vecs[i].eo);
        end
        drive(1'b0, '0, 1'b0);

        // Asynchronous reset between edges with 3 entries held.
        #2;
        reset = 1'b0;
        #1;
        check_all("async_reset", 0, 0, 0, 1, 0);
        step();
        step();
        reset = 1'b1;
        drive(1'b1, 64'h55, 1'b0);
        step();
        check_all("write_after_reset", 1, 64'h55, 1, 1, 0);
        drive(1'b0, '0, 1'b1);
        step();
        check_all("drain_after_reset", 0, 0, 0, 1, 0);

        // Pseudo-random traffic against a queue model.
        begin
            logic          en, ri, exp_ovf, wr, rd;
            logic [DW-1:0] din, head;
            exp_ovf = 1'b0;
            for (int c = 0; c < 300; c++) begin
                en  = ($urandom_range(0, 99) < 60);
                ri  = ($urandom_range(0, 99) < 50);
                din = {$urandom(), $urandom()};
                wr  = en && (exp_q.size() != DEPTH);
                rd  = ri && (exp_q.size() != 0);
                if (en && exp_q.size() == DEPTH) exp_ovf = 1'b1;
                drive(en, din, ri);
                step();
                if (rd) void'(exp_q.pop_front());
                if (wr) exp_q.push_back(din);
                head = (exp_q.size() != 0) ? exp_q[0] : '0;
                check_all($sformatf("rnd%0d", c), exp_q.size() != 0, head,
                          CW'(exp_q.size()), exp_q.size() != DEPTH, exp_ovf);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/gin_pe_input_fifo.md
Name: gin_pe_input_fifo

Overview:
- Receive-side buffer that sits directly downstream of a GIN multicast controller.
- Captures each word the controller forwards (its enable/data outputs) and returns a ready signal that feeds the controller's ready input.
- Presents the buffered words to the PE scratchpad loader through a first-word-fall-through valid/ready interface, decoupling GIN bus timing from PE consumption.

Parameters:
- DATA_WIDTH, 64, width of each buffered word; matches the GIN data bus.
- DEPTH, 4, number of entries; must be a power of two and at least 2.
- CNT_WIDTH, $clog2(DEPTH)+1, width of the occupancy count.

Ports:
- link_clk  in  1  single clock for the whole block.
- reset  in  1  asynchronous, active-low reset.
- data_in  in  DATA_WIDTH  word from the upstream multicast controller.
- enable_in  in  1  upstream word valid; a write occurs when enable_in & ready_out.
- ready_out  out  1  space available; drives the upstream controller's ready_in.
- data_out  out  DATA_WIDTH  head-of-queue word to the PE.
- valid_out  out  1  head word valid (queue not empty).
- ready_in  in  1  PE accepts the head word; a read occurs when valid_out & ready_in.
- count  out  CNT_WIDTH  current occupancy, 0..DEPTH.
- overflow_err  out  1  sticky flag: a write was attempted while full.

Behaviour:
- Storage: DEPTH x DATA_WIDTH register array.
  - Write pointer and read pointer are log2(DEPTH) bits each and wrap modulo DEPTH.
  - Occupancy is held in a separate count register.
- Reset (reset low, asynchronous), takes effect immediately regardless of the clock:
  - pointers = 0, count = 0, overflow_err = 0.
  - Therefore valid_out = 0, data_out = 0, ready_out = 1.
  - Array contents are not reset.
- ready_out = (count != DEPTH).
  - Derived only from registered state; it has no combinational dependence on ready_in or enable_in.
  - No write-through when full, even if a read happens in the same cycle.
- valid_out = (count != 0).
- data_out = valid_out ? mem[rd_ptr] : all-zeros.
  - First-word-fall-through: a word written in cycle N is visible on data_out in cycle N+1.
  - Write-to-output latency is 1 cycle.
- Write (enable_in & ready_out) at the rising edge: mem[wr_ptr] <= data_in, then wr_ptr increments.
- Read (valid_out & ready_in) at the rising edge: rd_ptr increments.
- Count update per edge:
  - write only: +1.
  - read only: -1.
  - both: unchanged; both pointers advance.
  - neither: unchanged.
- Full with a read: ready_out stays 0 in that cycle and returns to 1 in the next cycle.
- Empty: valid_out = 0, and ready_in is ignored (no pointer movement, no underflow).
- Overflow: enable_in = 1 while ready_out = 0.
  - The word is dropped and no state changes except overflow_err <= 1.
  - overflow_err stays set until reset.
  - In normal operation the upstream controller never does this; the flag exists for verification and debug.
- ready_in may toggle arbitrarily. data_out must remain stable while valid_out = 1 and ready_in = 0.
- Reset asserted mid-burst discards all contents; the first write after reset lands at entry 0.

Test Plan:
- Reset then idle: hold reset low 3 cycles, release, ready_in = 0 → ready_out = 1, valid_out = 0, count = 0, data_out = 0, overflow_err = 0.
- Fill and drain (DEPTH = 4): write 0x11, 0x22, 0x33, 0x44 on consecutive cycles with ready_in = 0.
  - Expect count steps 1..4 and ready_out = 0 after the 4th write.
  - Then set ready_in = 1: data_out shows 0x11, 0x22, 0x33, 0x44 on successive cycles, then valid_out = 0 and count = 0.
- Simultaneous read/write: with 2 entries held, assert enable_in and ready_in together for 6 cycles (data 0xA0..0xA5).
  - Expect count stays 2, output order preserved, and pointers wrap past index 3 without corruption.
- Full boundary: with 4 entries held, drive enable_in = 1 (0xEE) and ready_in = 1 in the same cycle.
  - Expect the head is popped and 0xEE is dropped; overflow_err = 1 next cycle; count = 3; ready_out = 1 next cycle.
- Back-pressure stability: with valid_out = 1, hold ready_in = 0 for 5 cycles → data_out is constant and count is unchanged.
- Reset mid-operation: assert reset asynchronously (between clock edges) with 3 entries held.
  - Expect valid_out = 0, count = 0 and ready_out = 1 immediately.
  - After release, write 0x55 → data_out = 0x55 the next cycle.
